// File: rtl/systolic_ctrl.sv
// Job sequencer for a ROWS x COLS systolic array. It loads the weights, streams the activations,
// and flags each result row. The array enable stays high for the whole job because the PEs have no stall.
module systolic_ctrl #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int PE_LATENCY = 4,
  parameter int PIPE_LAT   = PE_LATENCY * (ROWS + COLS - 1) + 2,
  parameter int VEC_W      = 16
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic                                      i_start,
  input  logic                                      i_load_w,
  input  logic [VEC_W-1:0]                          i_num_vecs,
  input  logic                                      i_abort,
  output logic                                      o_busy,
  output logic                                      o_done,
  output logic                                      o_arr_enable,
  output logic                                      o_arr_ld_weight,
  output logic                                      o_w_rd_en,
  output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0]  o_w_rd_addr,
  output logic                                      o_act_rd_en,
  output logic [VEC_W-1:0]                          o_act_rd_addr,
  output logic                                      o_res_valid,
  output logic [VEC_W-1:0]                          o_res_addr
);

  localparam int WA_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DLY_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_FEED, S_DRAIN} state_t;

  state_t           r_state;
  logic [VEC_W-1:0] r_num;
  logic [VEC_W-1:0] r_act_addr;
  logic [VEC_W-1:0] r_res_addr;
  logic [WA_W-1:0]  r_w_addr;
  logic [DLY_W-1:0] r_dly;
  logic             r_dly_run;
  logic             r_busy;
  logic             r_done;
  logic             r_ld_weight;
  logic             r_w_en;
  logic             r_act_en;
  logic             r_res_valid;

  logic [VEC_W-1:0] w_num_m1;
  logic             w_last_act;
  logic             w_last_res;

  assign w_num_m1   = r_num - VEC_W'(1);
  assign w_last_act = (r_act_addr == w_num_m1);
  assign w_last_res = r_res_valid && (r_res_addr == w_num_m1);

  // All outputs are registered and hold the values for the next cycle. Results follow the first
  // activation read by PIPE_LAT cycles. After that they run contiguously, so a small counter
  // takes the place of a delay line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_act_addr  <= '0;
      r_res_addr  <= '0;
      r_w_addr    <= '0;
      r_dly       <= '0;
      r_dly_run   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ld_weight <= 1'b0;
      r_w_en      <= 1'b0;
      r_act_en    <= 1'b0;
      r_res_valid <= 1'b0;
    end else if (i_abort && r_state != S_IDLE) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_act_addr  <= '0;
      r_res_addr  <= '0;
      r_w_addr    <= '0;
      r_dly       <= '0;
      r_dly_run   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ld_weight <= 1'b0;
      r_w_en      <= 1'b0;
      r_act_en    <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_ld_weight <= r_w_en;

      if (r_dly_run) begin
        if (r_dly == DLY_W'(PIPE_LAT - 1)) begin
          r_dly_run   <= 1'b0;
          r_res_valid <= 1'b1;
          r_res_addr  <= '0;
        end else begin
          r_dly <= r_dly + DLY_W'(1);
        end
      end

      if (r_res_valid) begin
        if (w_last_res) begin
          r_res_valid <= 1'b0;
          r_res_addr  <= '0;
        end else begin
          r_res_addr <= r_res_addr + VEC_W'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            r_num <= i_num_vecs;
            if (i_load_w) begin
              r_state  <= S_LOAD_W;
              r_busy   <= 1'b1;
              r_w_en   <= 1'b1;
              r_w_addr <= WA_W'(ROWS - 1);
            end else if (i_num_vecs != '0) begin
              r_state    <= S_FEED;
              r_busy     <= 1'b1;
              r_act_en   <= 1'b1;
              r_act_addr <= '0;
              r_dly      <= '0;
              r_dly_run  <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_LOAD_W: begin
          if (r_w_addr == '0) begin
            r_w_en <= 1'b0;
            if (r_num != '0) begin
              r_state    <= S_FEED;
              r_act_en   <= 1'b1;
              r_act_addr <= '0;
              r_dly      <= '0;
              r_dly_run  <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_w_addr <= r_w_addr - WA_W'(1);
          end
        end
        S_FEED: begin
          if (w_last_act) begin
            r_state    <= S_DRAIN;
            r_act_en   <= 1'b0;
            r_act_addr <= '0;
          end else begin
            r_act_addr <= r_act_addr + VEC_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_num == '0 || w_last_res) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_arr_enable    = r_busy;
  assign o_done          = r_done;
  assign o_arr_ld_weight = r_ld_weight;
  assign o_w_rd_en       = r_w_en;
  assign o_w_rd_addr     = r_w_addr;
  assign o_act_rd_en     = r_act_en;
  assign o_act_rd_addr   = r_act_addr;
  assign o_res_valid     = r_res_valid;
  assign o_res_addr      = r_res_addr;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed testbench for systolic_ctrl. The expected output of every cycle comes from a timing model that
// uses only the job parameters and the cycle number counted from the start sample.
module tb_systolic_ctrl;

  localparam int ROWS = 4;
  localparam int PIPE = 30;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic        loadW = 1'b0;
  logic [15:0] numVecs = '0;
  logic        abort = 1'b0;
  logic        busy, done, arrEnable, arrLdWeight, wRdEn, actRdEn, resValid;
  logic [1:0]  wRdAddr;
  logic [15:0] actRdAddr, resAddr;
  logic [40:0] obs, exp;
  int          checks = 0;
  int          failures = 0;

  systolic_ctrl #(.ROWS(4), .COLS(4), .PE_LATENCY(4), .PIPE_LAT(30), .VEC_W(16)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_load_w(loadW), .i_num_vecs(numVecs),
    .i_abort(abort), .o_busy(busy), .o_done(done), .o_arr_enable(arrEnable),
    .o_arr_ld_weight(arrLdWeight), .o_w_rd_en(wRdEn), .o_w_rd_addr(wRdAddr),
    .o_act_rd_en(actRdEn), .o_act_rd_addr(actRdAddr), .o_res_valid(resValid),
    .o_res_addr(resAddr)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, arrEnable, arrLdWeight, wRdEn, wRdAddr, actRdEn, actRdAddr,
                resValid, resAddr};

  // The expected outputs for cycle c of a job whose start was sampled at cycle 0.
  function automatic logic [40:0] expOut(input bit ld, input int n, input int c);
    int f, e, r;
    logic bE, wE, lE, aE, rE;
    logic [1:0] wa;
    logic [15:0] aa, ra;
    f = ld ? ROWS + 1 : 1;
    r = f + PIPE;
    if (n > 0) e = r + n - 1;
    else if (ld) e = ROWS + 1;
    else e = 0;
    bE = (c >= 1 && c <= e);
    wE = ld && c >= 1 && c <= ROWS;
    wa = wE ? 2'(ROWS - c) : 2'd0;
    lE = ld && c >= 2 && c <= ROWS + 1;
    aE = (n > 0) && c >= f && c <= f + n - 1;
    aa = aE ? 16'(c - f) : 16'd0;
    rE = (n > 0) && c >= r && c <= r + n - 1;
    ra = rE ? 16'(c - r) : 16'd0;
    return {bE, (c == e + 1), bE, lE, wE, wa, aE, aa, rE, ra};
  endfunction

  task automatic kick(input bit ld, input int n);
    @(negedge clk);
    loadW = ld;
    numVecs = 16'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_held got=%h exp=%h", obs, 41'd0);
    end
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_idle got=%h exp=%h", obs, 41'd0);
    end
  endtask

  task automatic test_load_feed;
    kick(1'b1, 3);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      exp = expOut(1'b1, 3, c);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL load_feed cyc=%0d got=%h exp=%h", c, obs, exp);
      end
    end
  endtask

  task automatic test_reuse;
    kick(1'b0, 2);
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      exp = expOut(1'b0, 2, c);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL reuse cyc=%0d got=%h exp=%h", c, obs, exp);
      end
    end
  endtask

  task automatic test_zero_vecs;
    kick(1'b1, 0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp = expOut(1'b1, 0, c);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL zero_load cyc=%0d got=%h exp=%h", c, obs, exp);
      end
    end
    kick(1'b0, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp = expOut(1'b0, 0, c);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL zero_noload cyc=%0d got=%h exp=%h", c, obs, exp);
      end
    end
  endtask

  task automatic test_start_ignored;
    kick(1'b1, 3);
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      exp = expOut(1'b1, 3, c);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL start_ignored cyc=%0d got=%h exp=%h", c, obs, exp);
      end
      start = (c == 10);
      if (c == 10) begin
        loadW = 1'b0;
        numVecs = 16'd9;
      end
    end
  endtask

  // This task is called right after test_start_ignored, so its start falls on cycle 39 of the previous job.
  task automatic test_back_to_back;
    kick(1'b0, 2);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      exp = expOut(1'b0, 2, c);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs, exp);
      end
    end
  endtask

  task automatic test_abort;
    int abCyc [3] = '{20, 37, 3};
    for (int k = 0; k < 3; k++) begin
      kick(1'b1, 3);
      for (int c = 1; c <= 42; c++) begin
        @(negedge clk);
        exp = (c <= abCyc[k]) ? expOut(1'b1, 3, c) : 41'd0;
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("[TB] FAIL abort_at_%0d cyc=%0d got=%h exp=%h", abCyc[k], c, obs, exp);
        end
        abort = (c == abCyc[k]);
      end
    end
    @(negedge clk);
    loadW = 1'b0;
    numVecs = 16'd2;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== '0) begin
        failures++;
        $display("[TB] FAIL idle_start_abort cyc=%0d got=%h exp=%h", c, obs, 41'd0);
      end
    end
  endtask

  task automatic test_reset_midjob;
    kick(1'b1, 3);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp = expOut(1'b1, 3, c);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL pre_reset cyc=%0d got=%h exp=%h", c, obs, exp);
      end
    end
    #1 rstN = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset got=%h exp=%h", obs, 41'd0);
    end
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL post_reset got=%h exp=%h", obs, 41'd0);
    end
  endtask

  task automatic test_max_vecs;
    kick(1'b0, 65535);
    for (int c = 1; c <= 65535 + 32; c++) begin
      @(negedge clk);
      exp = expOut(1'b0, 65535, c);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL max_vecs cyc=%0d got=%h exp=%h", c, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_feed();
    test_reuse();
    test_zero_vecs();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    test_reset_midjob();
    test_max_vecs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
